// File: rtl/l1a_fifo_param.sv
// Parametrised single-clock FIFO for L1A bookkeeping words (BXN, L1A number, tags).
// Full DEPTH capacity, registered occupancy flags, sticky ovf/udf, optional FWFT read side.
module l1a_fifo_param #(
    parameter int WIDTH      = 12,
    parameter int ADDR_W     = 8,
    parameter int AFULL_THR  = 240,
    parameter int AEMPTY_THR = 8,
    parameter int FWFT       = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sclr,
    input  logic [WIDTH-1:0]  din,
    input  logic              wen,
    input  logic              ren,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_valid,
    output logic              empty,
    output logic              full,
    output logic              afull,
    output logic              aempty,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    output logic              udf
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_THR);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_THR);

    generate
        if (!(AEMPTY_THR > 0 && AEMPTY_THR < AFULL_THR && AFULL_THR <= DEPTH)) begin : g_param_err
            $error("l1a_fifo_param: need 0 < AEMPTY_THR < AFULL_THR <= DEPTH");
        end
    endgenerate

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] waddr, raddr;
    logic [ADDR_W:0]   count_nxt;
    logic              wr_acc, rd_acc;

    // Acceptance uses the registered flags, i.e. the pre-edge state.
    assign wr_acc = wen && !full;
    assign rd_acc = ren && !empty;

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + (ADDR_W+1)'(1);
            2'b01:   count_nxt = count - (ADDR_W+1)'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !sclr) mem[waddr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            waddr  <= '0;
            raddr  <= '0;
            count  <= '0;
            empty  <= 1'b1;
            aempty <= 1'b1;
            full   <= 1'b0;
            afull  <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else if (sclr) begin
            waddr  <= '0;
            raddr  <= '0;
            count  <= '0;
            empty  <= 1'b1;
            aempty <= 1'b1;
            full   <= 1'b0;
            afull  <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_acc) waddr <= waddr + 1'b1;
            if (rd_acc) raddr <= raddr + 1'b1;
            count  <= count_nxt;
            empty  <= (count_nxt == '0);
            full   <= (count_nxt == DEPTH_C);
            afull  <= (count_nxt >= AFULL_C);
            aempty <= (count_nxt <= AEMPTY_C);
            if (wen && full)  ovf <= 1'b1;
            if (ren && empty) udf <= 1'b1;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented straight from the array; pop exposes the next one.
            assign dout_valid = !empty;
            assign dout       = empty ? '0 : mem[raddr];
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            logic             dv_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                end else if (sclr) begin
                    dv_q   <= 1'b0;
                end else begin
                    dv_q <= rd_acc;
                    if (rd_acc) dout_q <= mem[raddr];
                end
            end
            assign dout       = dout_q;
            assign dout_valid = dv_q;
        end
    endgenerate

endmodule
